// File: rtl/pipe_mux_pkg.sv
// pipe_mux_pkg: shared constants and helpers for the saturating select mux family.
package pipe_mux_pkg;
   localparam int MUX_MAX_IN = 16;
   function automatic int clog2_f(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) r = ((1 << r) < v) ? r + 1 : r;
      return r;
   endfunction
   function automatic int sat_sel(input int sel, input int n);
      return (sel >= n - 1) ? n - 1 : sel;
   endfunction
endpackage

// File: rtl/pipe_sel_mux_reg_sel_mux_comb.sv
// sel_mux_comb: combinational NUM_IN:1 select; out-of-range selects saturate to the top input.
module sel_mux_comb
   import pipe_mux_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 3,
   parameter int SEL_W  = 2
) (
   input  logic [NUM_IN*WIDTH-1:0] data,
   input  logic [SEL_W-1:0]        sel,
   output logic [WIDTH-1:0]        y
);
   // Every select code maps to a real input, so the lookup needs no range guard.
   logic [WIDTH-1:0] src [2**SEL_W];
   for (genvar k = 0; k < 2**SEL_W; k++) begin : g_src
      assign src[k] = data[sat_sel(k, NUM_IN)*WIDTH +: WIDTH];
   end
   assign y = src[sel];
endmodule

// File: rtl/pipe_sel_mux_reg.sv
// pipe_sel_mux_reg: registered saturating select with valid/ready and a 2-entry skid.
// Define PIPE_SEL_MUX_SEL_CHECK_EN to enable the sticky out-of-range select flag sel_err.
module pipe_sel_mux_reg
   import pipe_mux_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 3,
   parameter int SEL_W  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    flush,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    sel_err
);
   if (NUM_IN < 2 || NUM_IN > MUX_MAX_IN || SEL_W < clog2_f(NUM_IN)) begin : g_bad_cfg
      $fatal(1, "pipe_sel_mux_reg: NUM_IN must be 2..16 and 2**SEL_W >= NUM_IN");
   end
   logic [WIDTH-1:0] sel_data, skid_data;
   logic             skid_valid, accept, load, have;
   sel_mux_comb #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_mux (
      .data(in_data),
      .sel (in_sel),
      .y   (sel_data)
   );
   assign accept = in_valid & in_ready;
   assign load   = !out_valid | out_ready;
   assign have   = skid_valid | accept;
   // in_ready is the registered inverse of the next skid state, keeping out_ready off the ready path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         in_ready   <= 1'b1;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b1;
      end else begin
         out_valid  <= load ? have : 1'b1;
         skid_valid <= !load & have;
         in_ready   <= load | !have;
         if (load & have) out_data <= skid_valid ? skid_data : sel_data;
         if (!load & accept) skid_data <= sel_data;
      end
   end
`ifdef PIPE_SEL_MUX_SEL_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sel_err <= 1'b0;
      else if (accept && 32'(in_sel) >= NUM_IN) sel_err <= 1'b1;
   end
`else
   assign sel_err = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_sel_mux_reg.sv
// tb_pipe_sel_mux_reg: directed vectors plus a randomized queue-model run for pipe_sel_mux_reg.
module tb_pipe_sel_mux_reg;
`ifdef PIPE_SEL_MUX_SEL_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   logic        clk, rst_n, flush;
   logic [95:0] a_data;
   logic [1:0]  a_sel;
   logic        a_valid, a_ready, a_ovalid, a_oready, a_err;
   logic [31:0] a_odata;
   logic [159:0] b_data;
   logic [2:0]  b_sel;
   logic        b_valid, b_ready, b_ovalid, b_oready, b_err;
   logic [31:0] b_odata;
   int          checks, errors;
   logic        a_err_exp;

   pipe_sel_mux_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_sel(a_sel), .in_valid(a_valid),
      .in_ready(a_ready), .flush(flush), .out_data(a_odata), .out_valid(a_ovalid),
      .out_ready(a_oready), .sel_err(a_err)
   );
   pipe_sel_mux_reg #(.WIDTH(32), .NUM_IN(5), .SEL_W(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_sel(b_sel), .in_valid(b_valid),
      .in_ready(b_ready), .flush(flush), .out_data(b_odata), .out_valid(b_ovalid),
      .out_ready(b_oready), .sel_err(b_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer_a(input logic [31:0] w);
      a_data  = {3{w}};
      a_sel   = 2'd0;
      a_valid = 1'b1;
   endtask

   typedef struct {
      logic [1:0]  sel;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl[4];

   logic [31:0] q[$];
   logic [31:0] words[3];
   logic [31:0] exp_word;
   bit          acc, pop;
   int          dut_pops, model_pops;

   initial begin
      checks = 0; errors = 0; a_err_exp = 1'b0;
      tbl[0] = '{2'd0, 32'h11111111};
      tbl[1] = '{2'd1, 32'h22222222};
      tbl[2] = '{2'd2, 32'h33333333};
      tbl[3] = '{2'd3, 32'h33333333};
      rst_n = 1'b0; flush = 1'b0;
      a_data = '0; a_sel = '0; a_valid = 1'b0; a_oready = 1'b1;
      b_data = '0; b_sel = '0; b_valid = 1'b0; b_oready = 1'b1;
      #12;
      chk("reset_out_valid", a_ovalid, 0);
      chk("reset_out_data", a_odata, 0);
      chk("reset_in_ready", a_ready, 1);
      chk("reset_sel_err", a_err, 0);
      chk("reset_b_sel_err", b_err, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Back-to-back selects, one word per cycle.
      a_data = {32'h33333333, 32'h22222222, 32'h11111111};
      for (int i = 0; i < 4; i++) begin
         a_sel = tbl[i].sel; a_valid = 1'b1;
         step();
         chk($sformatf("sel%0d_valid", tbl[i].sel), a_ovalid, 1);
         chk($sformatf("sel%0d_data", tbl[i].sel), a_odata, tbl[i].exp);
      end
      a_valid = 1'b0;
      a_err_exp = CHK;
      chk("sel3_err", a_err, a_err_exp);
      step();
      chk("drain_valid", a_ovalid, 0);

      // Stall: A to output, B to skid, C held off.
      a_oready = 1'b0;
      offer_a(32'hA); step();
      chk("stall_a_data", a_odata, 32'hA);
      chk("stall_a_ready", a_ready, 1);
      offer_a(32'hB); step();
      chk("stall_b_ready", a_ready, 0);
      chk("stall_b_hold", a_odata, 32'hA);
      offer_a(32'hC); step();
      chk("stall_c_ready", a_ready, 0);
      chk("stall_c_hold", a_odata, 32'hA);
      a_oready = 1'b1; step();
      chk("release_b_data", a_odata, 32'hB);
      chk("release_b_ready", a_ready, 1);
      step();
      chk("release_c_data", a_odata, 32'hC);
      chk("release_c_valid", a_ovalid, 1);
      a_valid = 1'b0; step();
      chk("release_empty", a_ovalid, 0);

      // Flush with skid full, then a flush coincident with an accept.
      a_oready = 1'b0;
      offer_a(32'hD); step();
      offer_a(32'hE); step();
      chk("flush_full_ready", a_ready, 0);
      offer_a(32'hF); flush = 1'b1; step();
      flush = 1'b0; a_valid = 1'b0;
      chk("flush_valid", a_ovalid, 0);
      chk("flush_ready", a_ready, 1);
      a_oready = 1'b1;
      offer_a(32'h6); flush = 1'b1; step();
      flush = 1'b0; a_valid = 1'b0;
      chk("flush_accept_valid", a_ovalid, 0);
      step();
      chk("flush_word_gone", a_ovalid, 0);

      // Five-input instance: saturation and sticky sel_err.
      for (int k = 0; k < 5; k++) b_data[k*32 +: 32] = 32'h11111111 * (k + 1);
      b_sel = 3'd2; b_valid = 1'b1; step();
      chk("b_sel2_data", b_odata, 32'h33333333);
      chk("b_sel2_err", b_err, 0);
      b_sel = 3'd6; step();
      b_valid = 1'b0;
      chk("b_sel6_data", b_odata, 32'h55555555);
      chk("b_sel6_err", b_err, CHK);
      flush = 1'b1; step();
      flush = 1'b0; step();
      chk("b_err_after_flush", b_err, CHK);
      chk("b_flush_valid", b_ovalid, 0);

      // Asynchronous reset in the middle of a stall.
      a_oready = 1'b0;
      offer_a(32'h77); step();
      offer_a(32'h88); step();
      a_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", a_ovalid, 0);
      chk("async_rst_ready", a_ready, 1);
      chk("async_rst_b_err", b_err, 0);
      a_err_exp = 1'b0;
      step();
      rst_n = 1'b1;
      a_oready = 1'b1;
      offer_a(32'h99); step();
      a_valid = 1'b0;
      chk("post_rst_data", a_odata, 32'h99);
      chk("post_rst_valid", a_ovalid, 1);
      step();
      chk("post_rst_empty", a_ovalid, 0);

      // Random traffic against a two-slot queue model.
      dut_pops = 0; model_pops = 0;
      for (int c = 0; c < 10000; c++) begin
         for (int k = 0; k < 3; k++) words[k] = $urandom;
         a_data   = {words[2], words[1], words[0]};
         a_sel    = 2'($urandom_range(0, 3));
         a_valid  = ($urandom % 4) != 0;
         a_oready = ($urandom % 3) != 0;
         flush    = ($urandom % 64) == 0;
         exp_word = words[(a_sel >= 2) ? 2 : a_sel];
         acc = a_valid && (q.size() < 2);
         pop = (q.size() > 0) && a_oready;
         if (a_ovalid && a_oready && !flush) dut_pops++;
         step();
         if (acc && a_sel == 2'd3 && CHK) a_err_exp = 1'b1;
         if (flush) q.delete();
         else begin
            if (pop) begin
               void'(q.pop_front());
               model_pops++;
            end
            if (acc) q.push_back(exp_word);
         end
         chk("rnd_valid", a_ovalid, q.size() > 0);
         chk("rnd_ready", a_ready, q.size() < 2);
         if (q.size() > 0) chk("rnd_data", a_odata, q[0]);
      end
      flush = 1'b0; a_valid = 1'b0;
      chk("rnd_count", dut_pops, model_pops);
      chk("rnd_sel_err", a_err, a_err_exp);
      chk("rnd_b_err", b_err, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
